// File: rtl/pd_pkg.sv
// Shared definitions for the 110110 pattern-detector slice: serializer FSM
// state encoding, default word width and the pattern constant used by benches.
package pd_pkg;

  // Serializer FSM states.
  typedef enum logic {
    PD_SER_IDLE  = 1'b0,
    PD_SER_SHIFT = 1'b1
  } pd_ser_state_e;

  // Default parallel word width fed to the serializer.
  localparam int PD_WORD_W = 8;

  // Pattern recognised by the downstream detector.
  localparam logic [5:0] PD_PATTERN = 6'b110110;

endpackage : pd_pkg

// File: rtl/pd_bit_serializer.sv
// Parallel-to-serial feeder for the 110110 pattern detector.
// Words are accepted over valid/ready and leave one bit per bit_stb_i strobe
// on data_o/valid_o. On the last bit of a word a new word may be accepted on
// the same edge, so back-to-back words stream without a bubble.
// Build option: define PD_SER_LSB_FIRST_EN to emit bits LSB-first; otherwise
// bits leave MSB-first. Counting, handshake and timing are the same in both.
module pd_bit_serializer
  import pd_pkg::*;
#(
  parameter int WIDTH = PD_WORD_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  input  logic             bit_stb_i,
  output logic             data_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] words_sent_o
);

  localparam int            BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(WIDTH - 1);

  pd_ser_state_e    state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_shift_d;
  logic [BC_W-1:0]  bit_cnt_q;
  logic             data_q;
  logic             valid_q;
  logic [CNT_W-1:0] words_sent_q;
  logic             next_bit_d;
  logic             last_bit;
  logic             accept;

  assign last_bit     = (bit_cnt_q == LAST_CNT);
  assign word_ready_o = (state_q == PD_SER_IDLE) ||
                        ((state_q == PD_SER_SHIFT) && bit_stb_i && last_bit);
  assign accept       = word_valid_i && word_ready_o;

  // Select the outgoing bit and the shifted register for the build's bit order.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path; a missing
    // assignment would infer a latch.
`ifdef PD_SER_LSB_FIRST_EN
    next_bit_d   = sreg_q[0];
    sreg_shift_d = {1'b0, sreg_q[WIDTH-1:1]};
`else
    next_bit_d   = sreg_q[WIDTH-1];
    sreg_shift_d = {sreg_q[WIDTH-2:0], 1'b0};
`endif
  end

  // Two-state FSM with the shift register, bit counter, word counter and
  // registered serial outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_i) begin
      state_q      <= PD_SER_IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      data_q       <= 1'b0;
      valid_q      <= 1'b0;
      words_sent_q <= '0;
    end else begin
      case (state_q)
        PD_SER_IDLE: begin
          valid_q <= 1'b0;
          if (accept) begin
            sreg_q    <= word_i;
            bit_cnt_q <= '0;
            state_q   <= PD_SER_SHIFT;
          end
        end
        PD_SER_SHIFT: begin
          if (bit_stb_i) begin
            data_q    <= next_bit_d;
            valid_q   <= 1'b1;
            sreg_q    <= sreg_shift_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              words_sent_q <= words_sent_q + 1'b1;
              // A word accepted on the last-bit edge overrides the shift and
              // restarts the count: zero-gap streaming.
              if (accept) begin
                sreg_q    <= word_i;
                bit_cnt_q <= '0;
              end else begin
                state_q <= PD_SER_IDLE;
              end
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= PD_SER_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign busy_o       = (state_q == PD_SER_SHIFT);
  assign words_sent_o = words_sent_q;

endmodule : pd_bit_serializer

// File: tb/tb_pd_bit_serializer.sv
// Self-checking bench for pd_bit_serializer. A second instance with a 2-bit
// word counter shares all inputs so counter wrap can be observed.
// The reference model tracks "bits left in the current word" and indexes the
// stored word directly; it honours PD_SER_LSB_FIRST_EN for bit order.
module tb_pd_bit_serializer;
  import pd_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        bit_stb_i = 1'b0;
  logic        word_ready_o, data_o, valid_o, busy_o;
  logic [15:0] words_sent_o;
  logic        word_ready_w, data_w, valid_w, busy_w;
  logic [1:0]  words_sent_w;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_rem;     // bits of the current word still to emit
  logic [7:0] m_word;
  int         m_words;   // words fully emitted since reset
  logic       m_data, m_valid, m_busy, m_ready, m_acc;
  logic       obs_ready;

  pd_bit_serializer #(.WIDTH(PD_WORD_W), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o), .bit_stb_i(bit_stb_i), .data_o(data_o),
    .valid_o(valid_o), .busy_o(busy_o), .words_sent_o(words_sent_o)
  );

  pd_bit_serializer #(.WIDTH(PD_WORD_W), .CNT_W(2)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_w), .bit_stb_i(bit_stb_i), .data_o(data_w),
    .valid_o(valid_w), .busy_o(busy_w), .words_sent_o(words_sent_w)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_rem = 0; m_word = '0; m_words = 0;
    m_data = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_acc = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample the
  // combinational ready, then advance the model across the rising edge.
  task automatic tick(input logic v, input logic [7:0] w, input logic s);
    @(negedge clk_i);
    word_valid_i = v; word_i = w; bit_stb_i = s;
    #1;
    m_ready   = (m_rem == 0) || (s && m_rem == 1);
    m_acc     = v && m_ready;
    obs_ready = word_ready_o;
    @(posedge clk_i);
    if (m_rem > 0 && s) begin
`ifdef PD_SER_LSB_FIRST_EN
      m_data = m_word[8 - m_rem];
`else
      m_data = m_word[m_rem - 1];
`endif
      m_valid = 1'b1;
      m_rem--;
      if (m_rem == 0) m_words++;
    end else begin
      m_valid = 1'b0;
    end
    if (m_acc) begin
      m_word = w;
      m_rem  = 8;
    end
    m_busy = (m_rem > 0);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    word_valid_i = 1'b0; bit_stb_i = 1'b0;
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({valid_o, data_o, busy_o, word_ready_o} !== 4'b0001 || words_sent_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: v/d/b/rdy=%b%b%b%b cnt=%0d, expected 0001 cnt=0",
               valid_o, data_o, busy_o, word_ready_o, words_sent_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_single_word();
    logic [5:0] hist = '0;
    logic       seen = 1'b0;
    tick(1'b1, 8'hDB, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (valid_o) begin
        hist = {hist[4:0], data_o};
        if (hist == PD_PATTERN) seen = 1'b1;
      end
      checks++;
      if ({valid_o, data_o, busy_o} !== {m_valid, m_data, m_busy} ||
          words_sent_o !== 16'(m_words) || obs_ready !== m_ready) begin
        errors++;
        $display("FAIL single_word cyc%0d: v/d/b=%b%b%b rdy=%b cnt=%0d, expected %b%b%b rdy=%b cnt=%0d",
                 i, valid_o, data_o, busy_o, obs_ready, words_sent_o,
                 m_valid, m_data, m_busy, m_ready, m_words);
      end
    end
    checks++;
    if (words_sent_o !== 16'd1 || seen !== 1'b1) begin
      errors++;
      $display("FAIL single_word_done: cnt=%0d pattern_seen=%b, expected cnt=1 pattern_seen=1",
               words_sent_o, seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int vcount = 0;
    q.push_back(8'hDB); q.push_back(8'h36);
    for (int i = 0; i < 20; i++) begin
      tick(q.size() > 0, (q.size() > 0) ? q[0] : 8'h00, 1'b1);
      if (m_acc) void'(q.pop_front());
      if (valid_o) vcount++;
      checks++;
      if ({valid_o, data_o, busy_o} !== {m_valid, m_data, m_busy} ||
          words_sent_o !== 16'(m_words) || obs_ready !== m_ready) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: v/d/b=%b%b%b rdy=%b cnt=%0d, expected %b%b%b rdy=%b cnt=%0d",
                 i, valid_o, data_o, busy_o, obs_ready, words_sent_o,
                 m_valid, m_data, m_busy, m_ready, m_words);
      end
    end
    checks++;
    if (vcount != 16) begin
      errors++;
      $display("FAIL back_to_back_valid_cycles: got %0d, expected 16", vcount);
    end
  endtask

  task automatic test_strobe_gaps();
    tick(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 26; i++) begin
      tick(1'b0, 8'h00, (i % 3) == 2);
      checks++;
      if ({valid_o, data_o, busy_o} !== {m_valid, m_data, m_busy} ||
          words_sent_o !== 16'(m_words) || obs_ready !== m_ready) begin
        errors++;
        $display("FAIL strobe_gaps cyc%0d: v/d/b=%b%b%b rdy=%b cnt=%0d, expected %b%b%b rdy=%b cnt=%0d",
                 i, valid_o, data_o, busy_o, obs_ready, words_sent_o,
                 m_valid, m_data, m_busy, m_ready, m_words);
      end
    end
  endtask

  task automatic test_backpressure();
    logic pending = 1'b1;
    tick(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(pending, 8'hC9, (i % 2) == 0);
      if (m_acc) pending = 1'b0;
      checks++;
      if ({valid_o, data_o, busy_o} !== {m_valid, m_data, m_busy} ||
          words_sent_o !== 16'(m_words) || obs_ready !== m_ready) begin
        errors++;
        $display("FAIL backpressure cyc%0d: v/d/b=%b%b%b rdy=%b cnt=%0d, expected %b%b%b rdy=%b cnt=%0d",
                 i, valid_o, data_o, busy_o, obs_ready, words_sent_o,
                 m_valid, m_data, m_busy, m_ready, m_words);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    tick(1'b1, 8'hC3, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    @(negedge clk_i);
    bit_stb_i = 1'b1;
    #2 rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({valid_o, data_o, busy_o} !== 3'b000 || words_sent_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_async: v/d/b=%b%b%b cnt=%0d, expected 000 cnt=0",
               valid_o, data_o, busy_o, words_sent_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || obs_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_residue cyc%0d: v=%b b=%b rdy=%b, expected v=0 b=0 rdy=1",
                 i, valid_o, busy_o, obs_ready);
      end
    end
  endtask

  task automatic test_first_bit();
    logic exp_first;
`ifdef PD_SER_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    checks++;
    if (valid_o !== 1'b1 || data_o !== exp_first) begin
      errors++;
      $display("FAIL first_bit: v=%b d=%b, expected v=1 d=%b", valid_o, data_o, exp_first);
    end
    repeat (8) tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic       v = 1'b0;
    logic [7:0] w = '0;
    for (int i = 0; i < 600; i++) begin
      if (!v || m_acc) begin
        v = ($urandom_range(0, 1) == 1);
        w = 8'($urandom);
      end
      tick(v, w, $urandom_range(0, 9) < 7);
      checks++;
      if ({valid_o, data_o, busy_o} !== {m_valid, m_data, m_busy} ||
          words_sent_o !== 16'(m_words) || obs_ready !== m_ready ||
          words_sent_w !== 2'(m_words)) begin
        errors++;
        $display("FAIL random cyc%0d: v/d/b=%b%b%b rdy=%b cnt=%0d cnt2=%0d, expected %b%b%b rdy=%b cnt=%0d",
                 i, valid_o, data_o, busy_o, obs_ready, words_sent_o, words_sent_w,
                 m_valid, m_data, m_busy, m_ready, m_words);
      end
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    pulse_reset();
    while (sent < 5) begin
      tick(1'b1, 8'($urandom), 1'b1);
      if (m_acc) sent++;
    end
    repeat (10) tick(1'b0, 8'h00, 1'b1);
    checks++;
    if (words_sent_w !== 2'd1 || words_sent_o !== 16'd5) begin
      errors++;
      $display("FAIL wrap: cnt2=%0d cnt16=%0d, expected cnt2=1 cnt16=5",
               words_sent_w, words_sent_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_strobe_gaps();
    test_backpressure();
    test_reset_mid_word();
    test_first_bit();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pd_bit_serializer
